// File: rtl/float_to_q230_if.sv
// Operand/result bundle between the custom-instruction front end and float_to_q230.
interface float_to_q230_if;
  logic        clk_en;
  logic        start;
  logic [31:0] dataa;
  logic [31:0] result;
  logic        done;
  logic        sat;

  modport master (output clk_en, start, dataa, input result, done, sat);
  modport slave  (input clk_en, start, dataa, output result, done, sat);
endinterface

// File: rtl/float_to_q230.sv
// 3-stage IEEE-754 single -> signed Q2.30 converter for the CORDIC z register.
// Define ROUND_NEAREST_EN for round-half-away-from-zero on right shifts; default truncates.
module float_to_q230 (
  input  logic              clk,
  input  logic              reset,
  float_to_q230_if.slave    bus
);
  localparam int STAGES = 3;

  logic [STAGES-1:0] vld_pipe;

  // S1: raw operand fields
  logic        s1_s;
  logic [7:0]  s1_e;
  logic [22:0] s1_m;

  // S2: classified magnitude
  logic        s2_s;
  logic        s2_sat;
  logic [30:0] s2_mag;
  logic        s2_grd;

  logic [30:0] mag_n;
  logic        grd_n;
  logic        sat_n;
  logic [23:0] sig;
  logic [4:0]  rsh;
`ifdef ROUND_NEAREST_EN
  logic [55:0] ext;
`endif

  assign sig = {1'b1, s1_m};
  assign rsh = 5'(8'd120 - s1_e);

  always_comb begin
    mag_n = '0;
    grd_n = 1'b0;
    sat_n = 1'b0;
`ifdef ROUND_NEAREST_EN
    ext   = '0;
`endif
    if (s1_e == 8'hFF && s1_m != '0) begin
      mag_n = '0;                              // NaN maps to zero, no saturation
    end else if (s1_e >= 8'd128) begin
      sat_n = 1'b1;
    end else if (s1_e == 8'd0) begin
      mag_n = '0;
    end else if (s1_e >= 8'd120) begin
      // e-120 is just e[2:0] across 120..127
      mag_n = {7'b0, sig} << s1_e[2:0];
    end else if (s1_e >= 8'd96) begin
`ifdef ROUND_NEAREST_EN
      ext   = {sig, 32'b0} >> rsh;
      mag_n = {7'b0, ext[55:32]};
      grd_n = ext[31];
`else
      mag_n = {7'b0, sig >> rsh};
`endif
    end
  end

  // S3 combinational: round, negate, saturate
  logic [30:0] mag_r;
  logic [31:0] res_n;

  always_comb begin
    mag_r = s2_mag + {30'b0, s2_grd};
    res_n = {1'b0, mag_r};
    if (s2_sat)
      res_n = s2_s ? 32'h8000_0001 : 32'h7FFF_FFFF;
    else if (s2_s && mag_r != '0)
      res_n = -{1'b0, mag_r};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe   <= '0;
      s1_s       <= 1'b0;
      s1_e       <= '0;
      s1_m       <= '0;
      s2_s       <= 1'b0;
      s2_sat     <= 1'b0;
      s2_mag     <= '0;
      s2_grd     <= 1'b0;
      bus.result <= '0;
      bus.sat    <= 1'b0;
    end else if (bus.clk_en) begin
      vld_pipe <= {vld_pipe[STAGES-2:0], bus.start};
      s1_s     <= bus.dataa[31];
      s1_e     <= bus.dataa[30:23];
      s1_m     <= bus.dataa[22:0];
      s2_s     <= s1_s;
      s2_sat   <= sat_n;
      s2_mag   <= mag_n;
      s2_grd   <= grd_n;
      // result/sat only move on a completion so they hold between outputs
      if (vld_pipe[1]) begin
        bus.result <= res_n;
        bus.sat    <= s2_sat;
      end
    end
  end

  assign bus.done = vld_pipe[STAGES-1];
endmodule
